// File: rtl/calc_port_driver_if.sv
// calc_port_driver_if: operation handshake, calculator port and result signals of one driver.
interface calc_port_driver_if;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_cmd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        res_valid;
    logic [1:0]  res_resp;
    logic [31:0] res_data;
    logic        res_timeout;
    logic        err_stray;
    modport slave (
        input  op_valid, op_cmd, op_a, op_b, out_resp, out_data,
        output op_ready, req_cmd_out, req_data_out, res_valid, res_resp, res_data, res_timeout, err_stray
    );
    modport master (
        output op_valid, op_cmd, op_a, op_b, out_resp, out_data,
        input  op_ready, req_cmd_out, req_data_out, res_valid, res_resp, res_data, res_timeout, err_stray
    );
endinterface

// File: rtl/calc_port_driver.sv
// calc_port_driver: serializes one operation onto a calculator port and returns its response.
module calc_port_driver #(
    parameter int TIMEOUT = 16
) (
    input logic c_clk,
    input logic reset,
    calc_port_driver_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT, DONE} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t      state, next;
    logic [7:0]  cnt;
    logic [31:0] b_q;
    logic        accept, hit, expire, cap;
    logic [3:0]  req_cmd_d;
    logic [31:0] req_data_d, res_data_d;
    logic [1:0]  res_resp_d;
    logic        res_timeout_d, err_stray_d;
    assign bus.op_ready = state == IDLE;
    assign accept = bus.op_valid && state == IDLE;
    assign hit    = state == WAIT && bus.out_resp != 2'd0;
    assign expire = state == WAIT && cnt == LAST;
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= 8'd0;
            b_q              <= 32'd0;
            bus.req_cmd_out  <= 4'd0;
            bus.req_data_out <= 32'd0;
            bus.res_valid    <= 1'b0;
            bus.res_resp     <= 2'd0;
            bus.res_data     <= 32'd0;
            bus.res_timeout  <= 1'b0;
            bus.err_stray    <= 1'b0;
        end else begin
            state            <= next;
            cnt              <= state != WAIT ? 8'd0 : cnt == LAST ? cnt : cnt + 8'd1;
            b_q              <= accept ? bus.op_b : b_q;
            bus.req_cmd_out  <= req_cmd_d;
            bus.req_data_out <= req_data_d;
            bus.res_valid    <= next == DONE;
            bus.res_resp     <= res_resp_d;
            bus.res_data     <= res_data_d;
            bus.res_timeout  <= res_timeout_d;
            bus.err_stray    <= err_stray_d;
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept && bus.op_cmd != 4'd0 ? SEND_A : IDLE;
            SEND_A:  next = SEND_B;
            SEND_B:  next = WAIT;
            WAIT:    next = hit || expire ? DONE : WAIT;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end
    // Port outputs are registered, so they are computed from the state being entered.
    always_comb begin
        cap           = state == WAIT && next == DONE;
        req_cmd_d     = next == SEND_A ? bus.op_cmd : 4'd0;
        req_data_d    = next == SEND_A ? bus.op_a : next == SEND_B ? b_q : 32'd0;
        res_resp_d    = cap ? (hit ? bus.out_resp : 2'd0) : bus.res_resp;
        res_data_d    = cap ? (hit ? bus.out_data : 32'd0) : bus.res_data;
        res_timeout_d = cap ? !hit : bus.res_timeout;
        err_stray_d   = bus.err_stray || (state != WAIT && bus.out_resp != 2'd0);
    end
endmodule

// File: tb/tb_calc_port_driver.sv
// tb_calc_port_driver: directed and random operations against a cycle-level port/latency model.
module tb_calc_port_driver;
    localparam int T = 4;
    logic c_clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic exp_stray = 1'b0;
    calc_port_driver_if bus();
    calc_port_driver #(.TIMEOUT(T)) dut (.c_clk(c_clk), .reset(reset), .bus(bus));
    always #5 c_clk = ~c_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        case (cmd)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic offer(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        @(negedge c_clk);
        chk("ready_before_accept", 32'(bus.op_ready), 32'd1);
        bus.op_valid = 1'b1;
        bus.op_cmd = cmd;
        bus.op_a = a;
        bus.op_b = b;
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        offer(cmd, a, b);
        @(posedge c_clk);
        #1;
        bus.op_valid = 1'b0;
        bus.op_cmd = 4'($urandom);
        bus.op_a = $urandom;
        bus.op_b = $urandom;
    endtask

    // Follows one accepted operation cycle by cycle; k is the WAIT cycle of the response, 255 for none.
    task automatic track(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input int k, input logic [1:0] resp);
        int lat;
        logic [31:0] d;
        d = calc(cmd, a, b);
        lat = k < T ? k + 4 : T + 3;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge c_clk);
            if (c == 1) begin
                chk("sendA_cmd", 32'(bus.req_cmd_out), 32'(cmd));
                chk("sendA_data", bus.req_data_out, a);
            end
            if (c == 2) begin
                chk("sendB_cmd", 32'(bus.req_cmd_out), 32'd0);
                chk("sendB_data", bus.req_data_out, b);
            end
            if (c == 3) chk("wait_data", bus.req_data_out, 32'd0);
            chk("res_valid", 32'(bus.res_valid), 32'(c == lat));
            chk("op_ready", 32'(bus.op_ready), 32'(c == lat + 1));
            if (c == lat) begin
                chk("res_resp", 32'(bus.res_resp), k < T ? 32'(resp) : 32'd0);
                chk("res_data", bus.res_data, k < T ? d : 32'd0);
                chk("res_timeout", 32'(bus.res_timeout), 32'(k >= T));
                chk("err_stray", 32'(bus.err_stray), 32'(exp_stray));
            end
            bus.out_resp = c == k + 3 ? resp : 2'd0;
            bus.out_data = c == k + 3 ? d : 32'd0;
        end
    endtask

    initial begin
        logic [3:0] cmds [5];
        bus.op_valid = 1'b1;
        bus.op_cmd = 4'd1;
        bus.op_a = 32'd7;
        bus.op_b = 32'd9;
        bus.out_resp = 2'd0;
        bus.out_data = 32'd0;
        // Reset held 7 cycles with an operation offered: it must be ignored.
        repeat (7) @(posedge c_clk);
        @(negedge c_clk);
        chk("rst_req_cmd", 32'(bus.req_cmd_out), 32'd0);
        bus.op_valid = 1'b0;
        reset = 1'b0;
        chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
        chk("rst_req_data", bus.req_data_out, 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_resp", 32'(bus.res_resp), 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_res_timeout", 32'(bus.res_timeout), 32'd0);
        chk("rst_err_stray", 32'(bus.err_stray), 32'd0);

        issue(4'd1, 32'd5, 32'd3);
        track(4'd1, 32'd5, 32'd3, 2, 2'd1);
        chk("add_result_8", bus.res_data, 32'd8);

        issue(4'd5, 32'd1, 32'd4);
        track(4'd5, 32'd1, 32'd4, 255, 2'd1);
        chk("stray_before_late", 32'(bus.err_stray), 32'd0);
        bus.out_resp = 2'd1;
        bus.out_data = 32'h10;
        @(negedge c_clk);
        bus.out_resp = 2'd0;
        exp_stray = 1'b1;
        chk("late_resp_stray", 32'(bus.err_stray), 32'd1);
        chk("late_resp_ignored", 32'(bus.res_timeout), 32'd1);

        issue(4'd0, 32'hdead, 32'hbeef);
        repeat (6) begin
            @(negedge c_clk);
            chk("noop_cmd", 32'(bus.req_cmd_out), 32'd0);
            chk("noop_valid", 32'(bus.res_valid), 32'd0);
            chk("noop_ready", 32'(bus.op_ready), 32'd1);
        end

        // op_valid stays high while busy; the second operation's values appear during the first.
        offer(4'd2, 32'd10, 32'd3);
        @(posedge c_clk);
        #1;
        bus.op_cmd = 4'd1;
        bus.op_a = 32'd100;
        bus.op_b = 32'd200;
        track(4'd2, 32'd10, 32'd3, 0, 2'd1);
        @(posedge c_clk);
        #1;
        bus.op_valid = 1'b0;
        track(4'd1, 32'd100, 32'd200, 1, 2'd1);

        issue(4'd1, 32'd1, 32'd2);
        track(4'd1, 32'd1, 32'd2, 3, 2'd2);

        cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd9};
        for (int i = 0; i < 20; i++) begin
            logic [3:0] cmd;
            logic [31:0] a, b;
            int k;
            cmd = cmds[$urandom_range(0, 4)];
            a = $urandom;
            b = $urandom;
            k = $urandom_range(0, 3) == 0 ? 255 : int'($urandom_range(0, T - 1));
            issue(cmd, a, b);
            track(cmd, a, b, k, 2'($urandom_range(1, 3)));
        end

        issue(4'd6, 32'h80, 32'd2);
        repeat (4) @(negedge c_clk);
        reset = 1'b1;
        @(posedge c_clk);
        #1;
        reset = 1'b0;
        exp_stray = 1'b0;
        @(negedge c_clk);
        chk("wrst_op_ready", 32'(bus.op_ready), 32'd1);
        chk("wrst_req_cmd", 32'(bus.req_cmd_out), 32'd0);
        chk("wrst_req_data", bus.req_data_out, 32'd0);
        chk("wrst_err_stray", 32'(bus.err_stray), 32'd0);
        repeat (T + 4) begin
            chk("wrst_no_valid", 32'(bus.res_valid), 32'd0);
            @(negedge c_clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
